// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line port and the arbiter state.
package pmem_arbiter_pkg;

   localparam int unsigned LINE_W = 128;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned SEL_W  = 16;

   typedef logic [LINE_W-1:0] lc3b_line;
   typedef logic [ADDR_W-1:0] lc3b_line_addr;
   typedef logic [SEL_W-1:0]  lc3b_mem_sel;

   // Request payload a master presents toward memory
   typedef struct packed {
      lc3b_line      datm;
      logic          we;
      lc3b_mem_sel   sel;
      lc3b_line_addr adr;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } arb_state_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line-port signals.
interface pmem_arbiter_if;
   import pmem_arbiter_pkg::*;

   lc3b_line      i_datm, d_datm;
   logic          i_cyc, i_stb, d_cyc, d_stb;
   logic          i_we, d_we;
   lc3b_mem_sel   i_sel, d_sel;
   lc3b_line_addr i_adr, d_adr;
   lc3b_line      i_dats, d_dats;
   logic          i_ack, d_ack, i_rty, d_rty;

   lc3b_line      mem_dats;
   logic          mem_ack, mem_rty;
   lc3b_line      mem_datm;
   logic          mem_cyc, mem_stb, mem_we;
   lc3b_mem_sel   mem_sel;
   lc3b_line_addr mem_adr;

   // Arbiter view
   modport slave (
      input  i_datm, i_cyc, i_stb, i_we, i_sel, i_adr,
      input  d_datm, d_cyc, d_stb, d_we, d_sel, d_adr,
      output i_dats, i_ack, i_rty, d_dats, d_ack, d_rty,
      input  mem_dats, mem_ack, mem_rty,
      output mem_datm, mem_cyc, mem_stb, mem_we, mem_sel, mem_adr
   );

   // Cache and memory side view
   modport master (
      output i_datm, i_cyc, i_stb, i_we, i_sel, i_adr,
      output d_datm, d_cyc, d_stb, d_we, d_sel, d_adr,
      input  i_dats, i_ack, i_rty, d_dats, d_ack, d_rty,
      output mem_dats, mem_ack, mem_rty,
      input  mem_datm, mem_cyc, mem_stb, mem_we, mem_sel, mem_adr
   );

endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin 2:1 arbiter sharing the physical-memory line port between
// the I-cache and D-cache, with a sticky watchdog on stalled transactions.
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   pmem_arbiter_if.slave  bus,
   output logic           err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   arb_state_t       state_q, state_d;
   logic             last_q, last_d;   // 0: I served last, 1: D served last
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   logic     i_req, d_req;
   logic     grant_req;
   mem_req_t i_pl, d_pl, sel_pl;

   assign i_req = bus.i_cyc & bus.i_stb;
   assign d_req = bus.d_cyc & bus.d_stb;

   assign i_pl = '{datm: bus.i_datm, we: bus.i_we, sel: bus.i_sel, adr: bus.i_adr};
   assign d_pl = '{datm: bus.d_datm, we: bus.d_we, sel: bus.d_sel, adr: bus.d_adr};

   // State, priority, watchdog and error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Arbitration, grant release, watchdog and port steering
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      sel_pl    = '0;
      grant_req = 1'b0;
      bus.i_ack = 1'b0;
      bus.d_ack = 1'b0;
      bus.i_rty = i_req;
      bus.d_rty = d_req;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_req && d_req) state_d = last_q ? GRANT_I : GRANT_D;
            else if (i_req)     state_d = GRANT_I;
            else if (d_req)     state_d = GRANT_D;
         end
         GRANT_I: begin
            sel_pl    = i_pl;
            grant_req = i_req;
            bus.i_ack = bus.mem_ack;
            bus.i_rty = bus.mem_rty;
            if (bus.mem_ack) begin
               state_d = IDLE;
               last_d  = 1'b0;
               cnt_d   = '0;
            end else if (!i_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GRANT_D: begin
            sel_pl    = d_pl;
            grant_req = d_req;
            bus.d_ack = bus.mem_ack;
            bus.d_rty = bus.mem_rty;
            if (bus.mem_ack) begin
               state_d = IDLE;
               last_d  = 1'b1;
               cnt_d   = '0;
            end else if (!d_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (cnt_d == CNT_MAX) err_d = 1'b1;
   end

   assign bus.mem_datm = sel_pl.datm;
   assign bus.mem_we   = sel_pl.we;
   assign bus.mem_sel  = sel_pl.sel;
   assign bus.mem_adr  = sel_pl.adr;
   assign bus.mem_cyc  = grant_req;
   assign bus.mem_stb  = grant_req;

   // Read data is broadcast; ack qualifies it
   assign bus.i_dats = bus.mem_dats;
   assign bus.d_dats = bus.mem_dats;

   assign err = err_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_pmem_arbiter;
   import pmem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic err;
   int   checks = 0;
   int   failures = 0;

   pmem_arbiter_if bus ();

   pmem_arbiter #(.TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .err (err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_cyc = 1'b0; bus.i_stb = 1'b0; bus.i_we = 1'b0; bus.i_sel = '0; bus.i_adr = '0; bus.i_datm = '0;
      bus.d_cyc = 1'b0; bus.d_stb = 1'b0; bus.d_we = 1'b0; bus.d_sel = '0; bus.d_adr = '0; bus.d_datm = '0;
      bus.mem_ack = 1'b0; bus.mem_rty = 1'b0; bus.mem_dats = '0;
   endtask

   function automatic lc3b_line rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_adr = 12'h5A5; bus.i_we = 1'b1;
      bus.i_sel = 16'hFFFF; bus.i_datm = rand_line(); bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL rst_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      checks++; if (bus.mem_stb !== 1'b0) begin failures++; $display("FAIL rst_mem_stb got=%0h exp=0", bus.mem_stb); end
      checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
      checks++; if (bus.mem_sel !== 16'h0) begin failures++; $display("FAIL rst_mem_sel got=%0h exp=0", bus.mem_sel); end
      checks++; if (bus.mem_adr !== 12'h0) begin failures++; $display("FAIL rst_mem_adr got=%0h exp=0", bus.mem_adr); end
      checks++; if (bus.mem_datm !== '0) begin failures++; $display("FAIL rst_mem_datm got=%0h exp=0", bus.mem_datm); end
      checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL rst_i_ack got=%0h exp=0", bus.i_ack); end
      checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL rst_d_ack got=%0h exp=0", bus.d_ack); end
      checks++; if (bus.i_rty !== 1'b1) begin failures++; $display("FAIL rst_i_rty got=%0h exp=1", bus.i_rty); end
      checks++; if (bus.d_rty !== 1'b0) begin failures++; $display("FAIL rst_d_rty got=%0h exp=0", bus.d_rty); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err); end
      cyc();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_read();
      lc3b_line line;
      cyc();
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = 12'h0A3; bus.d_we = 1'b0;
      bus.d_sel = 16'hFFFF; bus.d_datm = rand_line();
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL sr_req_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      checks++; if (bus.d_rty !== 1'b1) begin failures++; $display("FAIL sr_req_d_rty got=%0h exp=1", bus.d_rty); end
      for (int k = 0; k < 3; k++) begin
         cyc();
         settle();
         checks++; if (bus.mem_cyc !== 1'b1) begin failures++; $display("FAIL sr_wait%0d_mem_cyc got=%0h exp=1", k, bus.mem_cyc); end
         checks++; if (bus.mem_adr !== 12'h0A3) begin failures++; $display("FAIL sr_wait%0d_mem_adr got=%0h exp=0a3", k, bus.mem_adr); end
         checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL sr_wait%0d_d_ack got=%0h exp=0", k, bus.d_ack); end
      end
      cyc();
      line = rand_line();
      bus.mem_ack = 1'b1; bus.mem_dats = line;
      settle();
      checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL sr_ack_d_ack got=%0h exp=1", bus.d_ack); end
      checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL sr_ack_i_ack got=%0h exp=0", bus.i_ack); end
      checks++; if (bus.d_dats !== line) begin failures++; $display("FAIL sr_d_dats got=%0h exp=%0h", bus.d_dats, line); end
      checks++; if (bus.i_dats !== line) begin failures++; $display("FAIL sr_i_dats got=%0h exp=%0h", bus.i_dats, line); end
      cyc();
      idle_inputs();
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL sr_post_mem_cyc got=%0h exp=0", bus.mem_cyc); end
   endtask

   task automatic test_tie_reset();
      lc3b_line_addr ia, da;
      ia = 12'h111; da = 12'h222;
      cyc();
      rst = 1'b1;
      idle_inputs();
      cyc();
      rst = 1'b0;
      bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_adr = ia;
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = da;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL tie_idle_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      checks++; if (bus.d_rty !== 1'b1) begin failures++; $display("FAIL tie_idle_d_rty got=%0h exp=1", bus.d_rty); end
      cyc();
      settle();
      checks++; if (bus.mem_adr !== da) begin failures++; $display("FAIL tie_first_adr got=%0h exp=%0h", bus.mem_adr, da); end
      checks++; if (bus.i_rty !== 1'b1) begin failures++; $display("FAIL tie_grant_i_rty got=%0h exp=1", bus.i_rty); end
      cyc();
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL tie_d_ack got=%0h exp=1", bus.d_ack); end
      checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL tie_i_ack_blocked got=%0h exp=0", bus.i_ack); end
      checks++; if (bus.i_rty !== 1'b1) begin failures++; $display("FAIL tie_ack_i_rty got=%0h exp=1", bus.i_rty); end
      cyc();
      bus.mem_ack = 1'b0; bus.d_cyc = 1'b0; bus.d_stb = 1'b0;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL tie_gap_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      cyc();
      settle();
      checks++; if (bus.mem_cyc !== 1'b1) begin failures++; $display("FAIL tie_second_mem_cyc got=%0h exp=1", bus.mem_cyc); end
      checks++; if (bus.mem_adr !== ia) begin failures++; $display("FAIL tie_second_adr got=%0h exp=%0h", bus.mem_adr, ia); end
      cyc();
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.i_ack !== 1'b1) begin failures++; $display("FAIL tie_i_ack got=%0h exp=1", bus.i_ack); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      lc3b_line_addr ia, da, exp_adr;
      bit exp_d;
      ia = 12'h3C3; da = 12'h7E7;
      cyc();
      bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_adr = ia;
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = da;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL b2b_idle_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      for (int k = 0; k < 4; k++) begin
         exp_d = (k % 2 == 0);
         exp_adr = exp_d ? da : ia;
         cyc();
         settle();
         checks++; if (bus.mem_adr !== exp_adr) begin failures++; $display("FAIL b2b_t%0d_adr got=%0h exp=%0h", k, bus.mem_adr, exp_adr); end
         cyc();
         bus.mem_ack = 1'b1;
         settle();
         checks++; if (bus.d_ack !== exp_d) begin failures++; $display("FAIL b2b_t%0d_d_ack got=%0h exp=%0h", k, bus.d_ack, exp_d); end
         checks++; if (bus.i_ack !== !exp_d) begin failures++; $display("FAIL b2b_t%0d_i_ack got=%0h exp=%0h", k, bus.i_ack, !exp_d); end
         cyc();
         bus.mem_ack = 1'b0;
         settle();
         checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL b2b_t%0d_gap_mem_cyc got=%0h exp=0", k, bus.mem_cyc); end
      end
      idle_inputs();
   endtask

   task automatic test_abort();
      lc3b_line_addr ia, da;
      ia = 12'h444; da = 12'h555;
      // D-only transaction so D is the last served side
      cyc();
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = da;
      cyc();
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL ab_pre_d_ack got=%0h exp=1", bus.d_ack); end
      cyc();
      idle_inputs();
      bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_adr = ia;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL ab_idle_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      cyc();
      settle();
      checks++; if (bus.mem_adr !== ia) begin failures++; $display("FAIL ab_grant_adr got=%0h exp=%0h", bus.mem_adr, ia); end
      cyc();
      bus.i_cyc = 1'b0;
      settle();
      checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL ab_drop_i_ack got=%0h exp=0", bus.i_ack); end
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL ab_drop_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      cyc();
      bus.i_cyc = 1'b1;
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = da;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL ab_post_idle_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      cyc();
      settle();
      checks++; if (bus.mem_adr !== ia) begin failures++; $display("FAIL ab_tie_adr got=%0h exp=%0h", bus.mem_adr, ia); end
      cyc();
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.i_ack !== 1'b1) begin failures++; $display("FAIL ab_tie_i_ack got=%0h exp=1", bus.i_ack); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_watchdog();
      cyc();
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_adr = 12'h0EE;
      for (int g = 1; g <= 12; g++) begin
         cyc();
         settle();
         checks++; if (err !== (g > 8)) begin failures++; $display("FAIL wd_g%0d_err got=%0h exp=%0h", g, err, (g > 8)); end
         checks++; if (bus.mem_cyc !== 1'b1) begin failures++; $display("FAIL wd_g%0d_mem_cyc got=%0h exp=1", g, bus.mem_cyc); end
      end
      cyc();
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL wd_late_d_ack got=%0h exp=1", bus.d_ack); end
      cyc();
      idle_inputs();
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL wd_post_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL wd_sticky_err got=%0h exp=1", err); end
   endtask

   task automatic test_reset_mid_write();
      cyc();
      bus.d_cyc = 1'b1; bus.d_stb = 1'b1; bus.d_we = 1'b1; bus.d_adr = 12'h9B9;
      bus.d_sel = 16'h00FF; bus.d_datm = rand_line();
      cyc();
      settle();
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rw_grant_mem_we got=%0h exp=1", bus.mem_we); end
      checks++; if (bus.mem_cyc !== 1'b1) begin failures++; $display("FAIL rw_grant_mem_cyc got=%0h exp=1", bus.mem_cyc); end
      cyc();
      rst = 1'b1;
      settle();
      checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL rw_rst_d_ack got=%0h exp=0", bus.d_ack); end
      cyc();
      rst = 1'b0;
      bus.d_cyc = 1'b0; bus.d_stb = 1'b0;
      bus.mem_ack = 1'b1;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL rw_post_mem_cyc got=%0h exp=0", bus.mem_cyc); end
      checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rw_post_mem_we got=%0h exp=0", bus.mem_we); end
      checks++; if (bus.mem_adr !== 12'h0) begin failures++; $display("FAIL rw_post_mem_adr got=%0h exp=0", bus.mem_adr); end
      checks++; if (bus.mem_sel !== 16'h0) begin failures++; $display("FAIL rw_post_mem_sel got=%0h exp=0", bus.mem_sel); end
      checks++; if (bus.mem_datm !== '0) begin failures++; $display("FAIL rw_post_mem_datm got=%0h exp=0", bus.mem_datm); end
      checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL rw_idle_ack_d_ack got=%0h exp=0", bus.d_ack); end
      checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL rw_idle_ack_i_ack got=%0h exp=0", bus.i_ack); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rw_post_err got=%0h exp=0", err); end
      cyc();
      bus.mem_ack = 1'b0;
      settle();
      checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL rw_still_idle_mem_cyc got=%0h exp=0", bus.mem_cyc); end
   endtask

   // Randomized transactions against a round-robin model (last served side)
   task automatic test_random();
      bit            m_last;   // 1: D served last
      bit            ireq, dreq, win, ack, rty;
      int            pat, dly;
      lc3b_line_addr ia, da, e_adr;
      lc3b_mem_sel   is, ds, e_sel;
      lc3b_line      idat, ddat, e_dat, rline;
      bit            iwe, dwe, e_we;
      logic          o_wack, o_lack, o_wrty, o_lrty;
      m_last = 1'b0;
      for (int t = 0; t < 40; t++) begin
         pat = $urandom_range(1, 3);
         ireq = (pat != 2); dreq = (pat >= 2);
         ia = 12'($urandom); da = 12'($urandom);
         is = 16'($urandom); ds = 16'($urandom);
         idat = rand_line(); ddat = rand_line();
         iwe = 1'($urandom); dwe = 1'($urandom);
         win = (ireq && dreq) ? !m_last : dreq;
         e_adr = win ? da : ia; e_sel = win ? ds : is;
         e_dat = win ? ddat : idat; e_we = win ? dwe : iwe;
         dly = $urandom_range(0, 3);
         cyc();
         bus.i_cyc = ireq; bus.i_stb = ireq; bus.i_adr = ia; bus.i_sel = is; bus.i_datm = idat; bus.i_we = iwe;
         bus.d_cyc = dreq; bus.d_stb = dreq; bus.d_adr = da; bus.d_sel = ds; bus.d_datm = ddat; bus.d_we = dwe;
         settle();
         checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL rnd%0d_idle_mem_cyc got=%0h exp=0", t, bus.mem_cyc); end
         for (int w = 0; w <= dly; w++) begin
            ack = (w == dly);
            rty = ack ? 1'b0 : 1'($urandom);
            rline = rand_line();
            cyc();
            bus.mem_ack = ack; bus.mem_rty = rty; bus.mem_dats = rline;
            settle();
            o_wack = win ? bus.d_ack : bus.i_ack;
            o_lack = win ? bus.i_ack : bus.d_ack;
            o_wrty = win ? bus.d_rty : bus.i_rty;
            o_lrty = win ? bus.i_rty : bus.d_rty;
            checks++; if (bus.mem_cyc !== 1'b1) begin failures++; $display("FAIL rnd%0d_mem_cyc got=%0h exp=1", t, bus.mem_cyc); end
            checks++; if (bus.mem_stb !== 1'b1) begin failures++; $display("FAIL rnd%0d_mem_stb got=%0h exp=1", t, bus.mem_stb); end
            checks++; if (bus.mem_adr !== e_adr) begin failures++; $display("FAIL rnd%0d_mem_adr got=%0h exp=%0h", t, bus.mem_adr, e_adr); end
            checks++; if (bus.mem_sel !== e_sel) begin failures++; $display("FAIL rnd%0d_mem_sel got=%0h exp=%0h", t, bus.mem_sel, e_sel); end
            checks++; if (bus.mem_we !== e_we) begin failures++; $display("FAIL rnd%0d_mem_we got=%0h exp=%0h", t, bus.mem_we, e_we); end
            checks++; if (bus.mem_datm !== e_dat) begin failures++; $display("FAIL rnd%0d_mem_datm got=%0h exp=%0h", t, bus.mem_datm, e_dat); end
            checks++; if (o_wack !== ack) begin failures++; $display("FAIL rnd%0d_win_ack got=%0h exp=%0h", t, o_wack, ack); end
            checks++; if (o_lack !== 1'b0) begin failures++; $display("FAIL rnd%0d_lose_ack got=%0h exp=0", t, o_lack); end
            checks++; if (o_wrty !== rty) begin failures++; $display("FAIL rnd%0d_win_rty got=%0h exp=%0h", t, o_wrty, rty); end
            checks++; if (o_lrty !== (win ? ireq : dreq)) begin failures++; $display("FAIL rnd%0d_lose_rty got=%0h exp=%0h", t, o_lrty, (win ? ireq : dreq)); end
            if (ack) begin
               checks++; if (bus.i_dats !== rline) begin failures++; $display("FAIL rnd%0d_i_dats got=%0h exp=%0h", t, bus.i_dats, rline); end
               checks++; if (bus.d_dats !== rline) begin failures++; $display("FAIL rnd%0d_d_dats got=%0h exp=%0h", t, bus.d_dats, rline); end
            end
         end
         m_last = win;
         cyc();
         idle_inputs();
         settle();
         checks++; if (bus.mem_cyc !== 1'b0) begin failures++; $display("FAIL rnd%0d_gap_mem_cyc got=%0h exp=0", t, bus.mem_cyc); end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd%0d_err got=%0h exp=0", t, err); end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie_reset();
      test_back_to_back();
      test_abort();
      test_watchdog();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
